// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  // Bit-count width for an N-bit word; the count only ever reaches N-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Shift register and bit counter; presents the completed word combinationally
// with a one-cycle word_done strobe so the holder can load on the same edge.
module sipo_shreg
  import sipo_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         clr,
  output logic [N-1:0] word,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = cnt_w(N);

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sr_q, sr_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    shifted;

  assign shifted = MSB_FIRST ? {sr_q[N-2:0], serial_in} : {serial_in, sr_q[N-1:1]};
  assign word    = shifted;
  assign busy    = busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_done = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (bit_valid) begin
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
          sr_d    = shifted;
        end
        SHIFT: begin
          if (cnt_q == CW'(N - 1)) begin
            // Last bit: the word leaves via `word` this cycle, so start clean.
            word_done = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
            sr_d      = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            sr_d  = shifted;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial receiver top: wraps the shifter with a valid/ready holding register
// and a sticky overrun flag for words completed while the holder is full.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         serial_in,
  input  logic         bit_valid,
  input  logic         clr,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  output logic         overrun,
  output logic         busy
);

  logic [N-1:0] word;
  logic         word_done;
  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;

  sipo_shreg #(.N(N), .MSB_FIRST(MSB_FIRST)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .clr       (clr),
    .word      (word),
    .word_done (word_done),
    .busy      (busy)
  );

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (word_done) begin
      // A word accepted on this edge frees the holder for the new one.
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (clr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: MSB-first and LSB-first instances, directed vectors.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in, bit_valid, bit_valid_l, clr, out_ready;
  logic [3:0] data_m, data_l;
  logic       vld_m, vld_l, ovr_m, ovr_l, busy_m, busy_l;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] q_m[$];
  logic [3:0] q_l[$];

  always #5 clk = ~clk;

  sipo_rx #(.N(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .clr(clr), .out_ready(out_ready), .data_out(data_m), .out_valid(vld_m),
    .overrun(ovr_m), .busy(busy_m)
  );

  sipo_rx #(.N(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid_l),
    .clr(clr), .out_ready(1'b1), .data_out(data_l), .out_valid(vld_l),
    .overrun(ovr_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1;
    serial_in = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_l(input logic b);
    bit_valid_l = 1'b1;
    serial_in   = b;
    tick();
    bit_valid_l = 1'b0;
  endtask

  task automatic send4(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) send(bits[i]);
  endtask

  initial begin
    rst = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; bit_valid_l = 1'b0;
    clr = 1'b0; out_ready = 1'b1;

    // Monitor: every accepted word is popped from its queue and compared.
    fork
      forever begin
        @(negedge clk);
        if (rst && vld_m && out_ready) begin
          if (q_m.size() == 0) chk("msb_unexpected_word", {28'd0, data_m}, 32'hFFFF);
          else chk("msb_word", {28'd0, data_m}, {28'd0, q_m.pop_front()});
        end
        if (rst && vld_l) begin
          if (q_l.size() == 0) chk("lsb_unexpected_word", {28'd0, data_l}, 32'hFFFF);
          else chk("lsb_word", {28'd0, data_l}, {28'd0, q_l.pop_front()});
        end
      end
    join_none

    #12;
    chk("rst_data", {28'd0, data_m}, 32'h0);
    chk("rst_valid", {31'd0, vld_m}, 32'h0);
    chk("rst_overrun", {31'd0, ovr_m}, 32'h0);
    chk("rst_busy", {31'd0, busy_m}, 32'h0);
    chk("rst_valid_l", {31'd0, vld_l}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // Basic word, ready held high: valid for exactly one cycle.
    q_m.push_back(4'b0110);
    send4(4'b0110);
    chk("lat_valid", {31'd0, vld_m}, 32'h1);
    chk("lat_busy", {31'd0, busy_m}, 32'h0);
    tick();
    chk("one_cycle_valid", {31'd0, vld_m}, 32'h0);

    // Overrun with consumer stalled, then clr.
    out_ready = 1'b0;
    q_m.push_back(4'b0110);
    send4(4'b0110);
    chk("ovr_before", {31'd0, ovr_m}, 32'h0);
    send4(4'b0111);
    chk("ovr_set", {31'd0, ovr_m}, 32'h1);
    chk("ovr_valid", {31'd0, vld_m}, 32'h1);
    chk("ovr_data", {28'd0, data_m}, 32'h6);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovr", {31'd0, ovr_m}, 32'h0);
    chk("clr_data", {28'd0, data_m}, 32'h6);
    chk("clr_valid", {31'd0, vld_m}, 32'h1);
    out_ready = 1'b1;
    tick();
    chk("drain_valid", {31'd0, vld_m}, 32'h0);

    // Back-to-back: first word accepted on the edge that completes the second.
    out_ready = 1'b0;
    q_m.push_back(4'b0110);
    send4(4'b0110);
    send(1'b0); send(1'b1); send(1'b1);
    out_ready = 1'b1;
    q_m.push_back(4'b0111);
    send(1'b1);
    chk("b2b_valid", {31'd0, vld_m}, 32'h1);
    chk("b2b_data", {28'd0, data_m}, 32'h7);
    chk("b2b_ovr", {31'd0, ovr_m}, 32'h0);
    tick();
    chk("b2b_drain", {31'd0, vld_m}, 32'h0);

    // clr with a bit present discards the partial word and that bit.
    send(1'b1); send(1'b1);
    clr = 1'b1; bit_valid = 1'b1; serial_in = 1'b1;
    tick();
    clr = 1'b0; bit_valid = 1'b0;
    chk("clr_busy", {31'd0, busy_m}, 32'h0);
    q_m.push_back(4'b0101);
    send4(4'b0101);
    tick();

    // Reset mid-word.
    send(1'b1); send(1'b1);
    chk("pre_rst_busy", {31'd0, busy_m}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy_m}, 32'h0);
    chk("rst_mid_valid", {31'd0, vld_m}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    q_m.push_back(4'b1001);
    send4(4'b1001);
    tick();

    // Gapped input: busy holds through idle cycles.
    q_m.push_back(4'b1011);
    begin
      logic [3:0] g;
      g = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        send(g[i]);
        if (i != 0) begin
          for (int k = 0; k < 3; k++) begin
            chk("gap_busy", {31'd0, busy_m}, 32'h1);
            tick();
          end
        end
      end
    end
    chk("gap_valid", {31'd0, vld_m}, 32'h1);
    tick();

    // LSB-first instance: bits 0,1,1,1 -> 4'b1110.
    q_l.push_back(4'b1110);
    send_l(1'b0); send_l(1'b1); send_l(1'b1); send_l(1'b1);
    chk("lsb_valid", {31'd0, vld_l}, 32'h1);
    tick(); tick(); tick();

    chk("msb_queue_empty", q_m.size(), 32'h0);
    chk("lsb_queue_empty", q_l.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
